// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types for the pipeline sequencer
// Contents: regbits_t register index, pipe_state_t sequencer states,
// pipe_ctrl_t bundle of latch enables/flushes, and mk_ctrl helper.
package pipeline_ctrl_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DDONE  = 2'd2,
        HALTED = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE = '0;

    // Back half of the pipe always moves on an advancing cycle; only the
    // front (PC, IF/ID) may be held, and either latch may be flushed.
    function automatic pipe_ctrl_t mk_ctrl(input logic front_en,
                                           input logic if_id_fl,
                                           input logic id_ex_fl);
        pipe_ctrl_t c;
        c.pc_en       = front_en;
        c.if_id_en    = front_en;
        c.id_ex_en    = 1'b1;
        c.ex_mem_en   = 1'b1;
        c.mem_wb_en   = 1'b1;
        c.if_id_flush = if_id_fl;
        c.id_ex_flush = id_ex_fl;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - load-use hazard compare
// Ports: mem_read/ex_rt describe the load in ID/EX; rs/rt/uses_rt describe
// the instruction in IF/ID; load_use is high when IF/ID needs the load result.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     mem_read,
    input  regbits_t ex_rt,
    input  regbits_t rs,
    input  regbits_t rt,
    input  logic     uses_rt,
    output logic     load_use
);

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = mem_read && (ex_rt != '0) &&
                      ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central sequencer for the 5-stage pipeline
// Produces PC/latch enables, flushes and the dcache request gate from
// ihit/dhit, load-use hazards, branch/jump redirects and HALT.
// Ports: CLK, RST (async, active-high); cache handshakes ihit/dhit;
// EX/MEM memory/halt flags; ID/EX and IF/ID hazard fields; branch_taken,
// jump_id; outputs pc_en, *_en, *_flush, dmem_req_en, halt (registered),
// cyc_cnt/stall_cnt/flush_cnt.
// Build option: PIPE_PERF_EN adds the performance counters; without it the
// counter outputs are tied to zero.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             ex_mem_dREN,
    input  logic             ex_mem_dWEN,
    input  logic             ex_mem_halt,
    input  logic             id_ex_memRead,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_usesRt,
    input  logic             branch_taken,
    input  logic             jump_id,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             dmem_req_en,
    output logic             halt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_t state, next_state;
    pipe_ctrl_t  ctrl;
    logic        memop, mem_ok, advance, load_use;

    load_use_detect u_load_use (
        .mem_read (id_ex_memRead),
        .ex_rt    (id_ex_rt),
        .rs       (if_id_rs),
        .rt       (if_id_rt),
        .uses_rt  (if_id_usesRt),
        .load_use (load_use)
    );

    // DDONE means the data access already completed while the I-fetch was
    // still outstanding; memory counts as satisfied until the pipe advances.
    assign memop   = ex_mem_dREN | ex_mem_dWEN;
    assign mem_ok  = !memop || dhit || (state == DDONE);
    assign advance = ihit && mem_ok && (state != HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            halt  <= 1'b0;
        end else begin
            state <= next_state;
            if ((state != HALTED) && (next_state == HALTED))
                halt <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        ctrl       = CTRL_IDLE;
        // HALT retires as soon as its own memory access (if any) is done,
        // from whichever waiting state the sequencer happens to be in.
        case (state)
            RUN: begin
                if (ex_mem_halt && mem_ok)       next_state = HALTED;
                else if (memop && !dhit)         next_state = DWAIT;
                else if (memop && dhit && !ihit) next_state = DDONE;
            end
            DWAIT: begin
                if (ex_mem_halt && mem_ok)       next_state = HALTED;
                else if (dhit && ihit)           next_state = RUN;
                else if (dhit)                   next_state = DDONE;
            end
            DDONE: begin
                if (ex_mem_halt)                 next_state = HALTED;
                else if (ihit)                   next_state = RUN;
            end
            HALTED:                              next_state = HALTED;
            default:                             next_state = RUN;
        endcase

        // A stalled cycle freezes everything; no partial advance, no flush.
        if (!RST && advance) begin
            if (branch_taken)   ctrl = mk_ctrl(1'b1, 1'b1, 1'b1);
            else if (load_use)  ctrl = mk_ctrl(1'b0, 1'b0, 1'b1);
            else if (jump_id)   ctrl = mk_ctrl(1'b1, 1'b1, 1'b0);
            else                ctrl = mk_ctrl(1'b1, 1'b0, 1'b0);
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign if_id_en    = ctrl.if_id_en;
    assign id_ex_en    = ctrl.id_ex_en;
    assign ex_mem_en   = ctrl.ex_mem_en;
    assign mem_wb_en   = ctrl.mem_wb_en;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign dmem_req_en = !RST && (state != DDONE) && (state != HALTED);

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (state != HALTED) begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (!advance || load_use)
                stall_q <= stall_q + CNT_W'(1);
            if (ctrl.if_id_flush || ctrl.id_ex_flush)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, ex_mem_dREN, ex_mem_dWEN, ex_mem_halt;
    logic        id_ex_memRead, if_id_usesRt, branch_taken, jump_id;
    logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, dmem_req_en, halt;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ex_mem_dREN(ex_mem_dREN), .ex_mem_dWEN(ex_mem_dWEN), .ex_mem_halt(ex_mem_halt),
        .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_usesRt(if_id_usesRt),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .dmem_req_en(dmem_req_en), .halt(halt),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    logic [6:0] ctrl_act;
    assign ctrl_act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_RUN  = 7'b1111100;
    localparam logic [6:0] C_LU   = 7'b0011101;
    localparam logic [6:0] C_JMP  = 7'b1111110;
    localparam logic [6:0] C_BR   = 7'b1111111;

`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "data already served" flag, halted flag, counters.
    logic        m_halted, m_ddone;
    logic [31:0] m_cyc, m_stall, m_flush;
    logic        new_op;

    task automatic clear_inputs();
        ihit = 0; dhit = 0; ex_mem_dREN = 0; ex_mem_dWEN = 0; ex_mem_halt = 0;
        id_ex_memRead = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
        if_id_usesRt = 0; branch_taken = 0; jump_id = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        clear_inputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        m_halted = 0; m_ddone = 0; m_cyc = 0; m_stall = 0; m_flush = 0; new_op = 1;
    endtask

    function automatic logic lu_rule(input logic mr, input logic [4:0] drt,
                                     input logic [4:0] rs, input logic [4:0] rt, input logic ur);
        return mr && drt != 0 && (drt == rs || (ur && drt == rt));
    endfunction

    task automatic rand_step(input int idx);
        logic memop, mem_ok, adv, lu;
        logic [6:0] e;
        @(negedge CLK);
        if (new_op) begin
            ex_mem_dREN = ($urandom_range(0, 2) == 0);
            ex_mem_dWEN = !ex_mem_dREN && ($urandom_range(0, 3) == 0);
            ex_mem_halt = ($urandom_range(0, 29) == 0);
        end
        memop = ex_mem_dREN | ex_mem_dWEN;
        ihit = ($urandom_range(0, 3) != 0);
        dhit = memop && !m_ddone && !m_halted && ($urandom_range(0, 2) == 0);
        id_ex_memRead = $urandom_range(0, 1);
        id_ex_rt = 5'($urandom_range(0, 3));
        if_id_rs = 5'($urandom_range(0, 3));
        if_id_rt = 5'($urandom_range(0, 3));
        if_id_usesRt = $urandom_range(0, 1);
        branch_taken = ($urandom_range(0, 7) == 0);
        jump_id = ($urandom_range(0, 5) == 0);
        #1;
        mem_ok = !memop || dhit || m_ddone;
        adv = ihit && mem_ok && !m_halted;
        lu = lu_rule(id_ex_memRead, id_ex_rt, if_id_rs, if_id_rt, if_id_usesRt);
        if (!adv) e = C_IDLE;
        else if (branch_taken) e = C_BR;
        else if (lu) e = C_LU;
        else if (jump_id) e = C_JMP;
        else e = C_RUN;
        check($sformatf("rand%0d_ctrl", idx), 32'(ctrl_act), 32'(e));
        check($sformatf("rand%0d_dreq", idx), 32'(dmem_req_en), 32'(!m_ddone && !m_halted));
        check($sformatf("rand%0d_halt", idx), 32'(halt), 32'(m_halted));
        check($sformatf("rand%0d_cyc", idx), cyc_cnt, PERF ? m_cyc : 32'd0);
        check($sformatf("rand%0d_stall", idx), stall_cnt, PERF ? m_stall : 32'd0);
        check($sformatf("rand%0d_flush", idx), flush_cnt, PERF ? m_flush : 32'd0);
        @(posedge CLK);
        if (!m_halted) begin
            m_cyc++;
            if (!adv || lu) m_stall++;
            if (e[1] || e[0]) m_flush++;
            if (ex_mem_halt && mem_ok) m_halted = 1;
            else m_ddone = (m_ddone || (memop && dhit)) && !adv;
        end
        new_op = adv;
    endtask

    typedef struct {
        string      name;
        logic       ihit, dhit, dren, dwen, mr;
        logic [4:0] drt, rs, rt;
        logic       ur, br, jmp;
        logic [6:0] exp_ctrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic ih, input logic dh, input logic dr,
                           input logic dw, input logic mr, input logic [4:0] drt,
                           input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                           input logic br, input logic jmp, input logic [6:0] ec);
        vec_t v;
        v.name = n; v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.mr = mr;
        v.drt = drt; v.rs = rs; v.rt = rt; v.ur = ur; v.br = br; v.jmp = jmp; v.exp_ctrl = ec;
        vecs.push_back(v);
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        m_halted = 0; m_ddone = 0; m_cyc = 0; m_stall = 0; m_flush = 0; new_op = 1;

        //            name          ih dh dr dw mr drt rs rt ur br jm  expected
        add_vec("plain",            1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, C_RUN);
        add_vec("no_ihit",          0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, C_IDLE);
        add_vec("lu_rs",            1, 0, 0, 0, 1, 5,  5, 0, 0, 0, 0, C_LU);
        add_vec("lu_r0",            1, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, C_RUN);
        add_vec("lu_rt",            1, 0, 0, 0, 1, 7,  3, 7, 1, 0, 0, C_LU);
        add_vec("rt_unused",        1, 0, 0, 0, 1, 7,  3, 7, 0, 0, 0, C_RUN);
        add_vec("no_memread",       1, 0, 0, 0, 0, 5,  5, 5, 1, 0, 0, C_RUN);
        add_vec("br_lu_jmp",        1, 0, 0, 0, 1, 5,  5, 0, 0, 1, 1, C_BR);
        add_vec("jump",             1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, C_JMP);
        add_vec("jump_lu",          1, 0, 0, 0, 1, 9,  9, 0, 0, 0, 1, C_LU);
        add_vec("load_hit",         1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, C_RUN);
        add_vec("load_miss",        1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, C_IDLE);
        add_vec("store_hit_br",     1, 1, 0, 1, 0, 0,  0, 0, 0, 1, 0, C_BR);
        add_vec("store_miss_br",    1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, C_IDLE);
        add_vec("br_no_ihit",       0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, C_IDLE);

        // T1: reset dominates ihit
        @(negedge CLK);
        ihit = 1;
        #1;
        check("rst_ctrl", 32'(ctrl_act), 32'(C_IDLE));
        check("rst_dreq", 32'(dmem_req_en), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_cyc", cyc_cnt, 32'd0);
        @(negedge CLK);
        RST = 0;
        #1;
        check("post_rst_ctrl", 32'(ctrl_act), 32'(C_RUN));
        check("post_rst_dreq", 32'(dmem_req_en), 32'd1);

        foreach (vecs[i]) begin
            do_reset();
            ihit = vecs[i].ihit; dhit = vecs[i].dhit;
            ex_mem_dREN = vecs[i].dren; ex_mem_dWEN = vecs[i].dwen;
            id_ex_memRead = vecs[i].mr; id_ex_rt = vecs[i].drt;
            if_id_rs = vecs[i].rs; if_id_rt = vecs[i].rt; if_id_usesRt = vecs[i].ur;
            branch_taken = vecs[i].br; jump_id = vecs[i].jmp;
            #1;
            check({"vec_", vecs[i].name}, 32'(ctrl_act), 32'(vecs[i].exp_ctrl));
            check({"vec_dreq_", vecs[i].name}, 32'(dmem_req_en), 32'd1);
        end

        // T3: data served before the instruction
        do_reset();
        ex_mem_dREN = 1; dhit = 1; ihit = 0;
        #1;
        check("t3_c1_ctrl", 32'(ctrl_act), 32'(C_IDLE));
        check("t3_c1_dreq", 32'(dmem_req_en), 32'd1);
        @(negedge CLK);
        dhit = 0;
        #1;
        check("t3_c2_dreq", 32'(dmem_req_en), 32'd0);
        check("t3_c2_ctrl", 32'(ctrl_act), 32'(C_IDLE));
        @(negedge CLK);
        ihit = 1;
        #1;
        check("t3_c3_ctrl", 32'(ctrl_act), 32'(C_RUN));
        check("t3_c3_dreq", 32'(dmem_req_en), 32'd0);
        @(negedge CLK);
        ex_mem_dREN = 0;
        #1;
        check("t3_c4_dreq", 32'(dmem_req_en), 32'd1);
        check("t3_c4_ctrl", 32'(ctrl_act), 32'(C_RUN));

        // T5: halting store completes on cycle 4
        do_reset();
        ex_mem_halt = 1; ex_mem_dWEN = 1; ihit = 1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("t5_wait%0d_ctrl", c), 32'(ctrl_act), 32'(C_IDLE));
            check($sformatf("t5_wait%0d_halt", c), 32'(halt), 32'd0);
            @(negedge CLK);
        end
        dhit = 1;
        #1;
        check("t5_c4_ctrl", 32'(ctrl_act), 32'(C_RUN));
        check("t5_c4_halt", 32'(halt), 32'd0);
        @(negedge CLK);
        dhit = 0;
        for (int c = 0; c < 20; c++) begin
            ihit = 1; branch_taken = $urandom_range(0, 1); jump_id = $urandom_range(0, 1);
            #1;
            check($sformatf("t5_h%0d_ctrl", c), 32'(ctrl_act), 32'(C_IDLE));
            check($sformatf("t5_h%0d_dreq", c), 32'(dmem_req_en), 32'd0);
            check($sformatf("t5_h%0d_halt", c), 32'(halt), 32'd1);
            @(negedge CLK);
        end
        RST = 1;
        #1;
        check("t5_rst_halt", 32'(halt), 32'd0);
        check("t5_rst_ctrl", 32'(ctrl_act), 32'(C_IDLE));

        // T6: 2 miss stalls + 1 load-use in 10 cycles
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            clear_inputs();
            ihit = 1;
            if (c <= 3) ex_mem_dREN = 1;
            if (c == 3) dhit = 1;
            if (c == 4) begin id_ex_memRead = 1; id_ex_rt = 5; if_id_rs = 5; end
            @(negedge CLK);
        end
        clear_inputs();
        #1;
        check("t6_cyc", cyc_cnt, PERF ? 32'd10 : 32'd0);
        check("t6_stall", stall_cnt, PERF ? 32'd3 : 32'd0);
        check("t6_flush", flush_cnt, PERF ? 32'd1 : 32'd0);

        // Randomized run against the model, with halts and mid-miss resets
        do_reset();
        begin
            int halted_cycles = 0;
            for (int i = 0; i < 600; i++) begin
                rand_step(i);
                if (m_halted) halted_cycles++;
                if (halted_cycles > 5 || $urandom_range(0, 99) == 0) begin
                    halted_cycles = 0;
                    do_reset();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
